// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
//
// Parcel queue between instruction fetch and decode. Fetch words of
// FETCH_PARCELS 16-bit parcels go into a circular parcel array. Each cycle the
// head parcel(s) are decoded into one whole RVC or 32-bit instruction. This
// includes a 32-bit instruction whose halves arrived in different fetch words.
// No pc is stored per entry. The pc of every parcel follows from head_pc and
// its distance from the head.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low
//   fetch_valid   fetch word present
//   fetch_ready   room for a whole fetch word (uses the registered count only)
//   fetch_pc      byte address of fetch word, aligned to 2*FETCH_PARCELS
//   fetch_data    parcel i belongs to fetch_pc + 2*i
//   fetch_exc     fetch fault for every parcel of the word
//   fetch_ecause  fault cause
//   flush         redirect: drop contents and the current fetch word
//   flush_pc      new head pc
//   dec_ready     decode accepts the head instruction
//   dec_valid     a complete instruction (or a head fault) is at the head
//   dec_pc        instruction pc
//   dec_npc       pc + 2 (RVC or head fault) or pc + 4
//   dec_instr     instruction; RVC zero-extended in [31:16]
//   dec_exc       fault flag
//   dec_ecause    fault cause
//   dec_etval     pc of the faulting parcel
//   count         parcels held
// -----------------------------------------------------------------------------
module decode_buffer #(
    parameter int          DEPTH         = 8,
    parameter int          FETCH_PARCELS = 2,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetch_valid,
    output logic                         fetch_ready,
    input  logic [31:0]                  fetch_pc,
    input  logic [16*FETCH_PARCELS-1:0]  fetch_data,
    input  logic                         fetch_exc,
    input  logic [3:0]                   fetch_ecause,
    input  logic                         flush,
    input  logic [31:0]                  flush_pc,
    input  logic                         dec_ready,
    output logic                         dec_valid,
    output logic [31:0]                  dec_pc,
    output logic [31:0]                  dec_npc,
    output logic [31:0]                  dec_instr,
    output logic                         dec_exc,
    output logic [3:0]                   dec_ecause,
    output logic [31:0]                  dec_etval,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);          // pointer width
    localparam int CW = PW + 1;                 // count width
    localparam int OW = $clog2(FETCH_PARCELS);  // parcel offset within a fetch word

    // Parcel storage (data only, never reset)
    logic [15:0]      data_q   [DEPTH];
    logic [DEPTH-1:0] exc_q;
    logic [3:0]       ecause_q [DEPTH];

    // Control state
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_pc_q, head_pc_d;

    // Push side
    logic [31:0]   tail_pc;
    logic          stale;
    logic [OW-1:0] off;
    logic          push_acc;
    logic          push_wr;
    logic [CW-1:0] pushed;
    logic [FETCH_PARCELS-1:0] wen;
    logic [PW-1:0] widx [FETCH_PARCELS];

    // Head decode
    logic [PW-1:0] rd1;
    logic [15:0]   h0, h1;
    logic          has1, has2;
    logic          head_exc, sec_exc, is32, single;
    logic          pop;
    logic [1:0]    popped;

    logic          unused_bits;

    assign tail_pc = head_pc_q + {{(31-CW){1'b0}}, count_q, 1'b0};
    // A word whose address does not match where the queue tail is expected
    // belongs to a path abandoned by an earlier redirect.
    assign stale   = fetch_pc[31:OW+1] != tail_pc[31:OW+1];
    // After a redirect to a mid-word pc, the leading parcels of the first word
    // are skipped.
    assign off     = tail_pc[OW:1];

    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_PARCELS);
    assign push_acc    = fetch_valid & fetch_ready & ~flush;
    assign push_wr     = push_acc & ~stale;
    assign pushed      = push_wr ? (CW'(FETCH_PARCELS) - CW'(off)) : '0;

    always_comb begin
        for (int i = 0; i < FETCH_PARCELS; i++) begin
            wen[i]  = push_wr && (OW'(i) >= off);
            widx[i] = wr_q + PW'(i) - PW'(off);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_PARCELS; i++) begin
            if (wen[i]) begin
                data_q[widx[i]]   <= fetch_data[16*i +: 16];
                exc_q[widx[i]]    <= fetch_exc;
                ecause_q[widx[i]] <= fetch_ecause;
            end
        end
    end

    // The second parcel comes from the entry after the head. It wraps from
    // DEPTH-1 to 0.
    assign rd1      = rd_q + PW'(1);
    assign h0       = data_q[rd_q];
    assign h1       = data_q[rd1];
    assign has1     = count_q != '0;
    assign has2     = count_q >= CW'(2);
    assign head_exc = exc_q[rd_q];
    assign is32     = h0[1:0] == 2'b11;
    // A faulting head parcel is issued alone, so the fault is not held back
    // while waiting for a second parcel that may never arrive.
    assign single   = head_exc | ~is32;
    assign sec_exc  = is32 & has2 & exc_q[rd1];

    assign dec_valid  = has1 & (single | has2);
    assign dec_pc     = head_pc_q;
    assign dec_npc    = head_pc_q + (single ? 32'd2 : 32'd4);
    assign dec_instr  = single ? {16'h0000, h0} : {h1, h0};
    assign dec_exc    = has1 & (head_exc | sec_exc);
    assign dec_ecause = !dec_exc ? 4'h0  : (head_exc ? ecause_q[rd_q] : ecause_q[rd1]);
    assign dec_etval  = !dec_exc ? 32'h0 : (head_exc ? head_pc_q : head_pc_q + 32'd2);
    assign count      = count_q;

    assign pop    = dec_valid & dec_ready;
    assign popped = !pop ? 2'd0 : (single ? 2'd1 : 2'd2);

    always_comb begin
        count_d   = count_q + pushed - CW'(popped);
        rd_d      = rd_q + PW'(popped);
        wr_d      = wr_q + PW'(pushed);
        head_pc_d = head_pc_q + {29'b0, popped, 1'b0};
        if (flush) begin
            // Realign the read pointer with the write pointer. This empties the
            // queue without moving the storage position.
            count_d   = '0;
            rd_d      = wr_q;
            wr_d      = wr_q;
            head_pc_d = flush_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
        end
    end

    // Byte-offset bits of the fetch address and the tail pc never affect the
    // result.
    assign unused_bits = ^{fetch_pc[OW:0], tail_pc[0]};

endmodule

// File: tb/tb_decode_buffer.sv
// -----------------------------------------------------------------------------
// tb_decode_buffer
//
// Directed test for decode_buffer with DEPTH=8 and FETCH_PARCELS=2. Inputs
// change 1 time unit after the rising edge. Outputs are compared at that same
// point, after the register update has settled.
// -----------------------------------------------------------------------------
module tb_decode_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_data;
    logic        fetch_exc;
    logic [3:0]  fetch_ecause;
    logic        flush;
    logic [31:0] flush_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_npc;
    logic [31:0] dec_instr;
    logic        dec_exc;
    logic [3:0]  dec_ecause;
    logic [31:0] dec_etval;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    decode_buffer #(
        .DEPTH        (8),
        .FETCH_PARCELS(2),
        .RESET_PC     (32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_data  (fetch_data),
        .fetch_exc   (fetch_exc),
        .fetch_ecause(fetch_ecause),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_npc     (dec_npc),
        .dec_instr   (dec_instr),
        .dec_exc     (dec_exc),
        .dec_ecause  (dec_ecause),
        .dec_etval   (dec_etval),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data,
                        input logic exc, input logic [3:0] ec);
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_data   = data;
        fetch_exc    = exc;
        fetch_ecause = ec;
        tick();
        fetch_valid  = 1'b0;
        fetch_exc    = 1'b0;
        fetch_ecause = 4'h0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        tick();
        flush    = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_pc     = 32'h0;
        fetch_data   = 32'h0;
        fetch_exc    = 1'b0;
        fetch_ecause = 4'h0;
        flush        = 1'b0;
        flush_pc     = 32'h0;
        dec_ready    = 1'b0;

        // Reset state
        #3;
        chk("rst_count", {28'h0, count}, 32'd0);
        chk("rst_dec_valid", {31'h0, dec_valid}, 32'd0);
        chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'd1);
        chk("rst_dec_exc", {31'h0, dec_exc}, 32'd0);
        #5;
        reset = 1'b1;
        tick();
        chk("rst_head_pc", dec_pc, 32'h0);

        // Basic fetch: one 32-bit instruction at 0x0
        push(32'h0, 32'h0000_0013, 1'b0, 4'h0);
        chk("basic_valid", {31'h0, dec_valid}, 32'd1);
        chk("basic_instr", dec_instr, 32'h0000_0013);
        chk("basic_pc", dec_pc, 32'h0);
        chk("basic_npc", dec_npc, 32'h4);
        chk("basic_count", {28'h0, count}, 32'd2);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("basic_drained", {28'h0, count}, 32'd0);
        chk("basic_empty_valid", {31'h0, dec_valid}, 32'd0);

        // RVC pair: parcel 0x4505 at 0x100, 0x0001 at 0x102
        do_flush(32'h100);
        chk("rvc_flush_count", {28'h0, count}, 32'd0);
        push(32'h100, 32'h0001_4505, 1'b0, 4'h0);
        chk("rvc0_instr", dec_instr, 32'h0000_4505);
        chk("rvc0_pc", dec_pc, 32'h100);
        chk("rvc0_npc", dec_npc, 32'h102);
        dec_ready = 1'b1;
        tick();
        chk("rvc1_instr", dec_instr, 32'h0000_0001);
        chk("rvc1_pc", dec_pc, 32'h102);
        chk("rvc1_npc", dec_npc, 32'h104);
        chk("rvc1_count", {28'h0, count}, 32'd1);
        tick();
        dec_ready = 1'b0;
        chk("rvc_end_count", {28'h0, count}, 32'd0);

        // Straddle: head at 0x202 is the low half 0x0513 of a 32-bit
        // instruction. Its high half 0x0010 arrives in the next word at 0x204.
        do_flush(32'h202);
        push(32'h200, 32'h0513_0010, 1'b0, 4'h0);
        chk("strad_count1", {28'h0, count}, 32'd1);
        chk("strad_wait_valid", {31'h0, dec_valid}, 32'd0);
        push(32'h204, 32'hABCD_0010, 1'b0, 4'h0);
        chk("strad_count3", {28'h0, count}, 32'd3);
        chk("strad_valid", {31'h0, dec_valid}, 32'd1);
        chk("strad_instr", dec_instr, 32'h0010_0513);
        chk("strad_pc", dec_pc, 32'h202);
        chk("strad_npc", dec_npc, 32'h206);
        dec_ready = 1'b1;
        tick();
        chk("strad_tail_instr", dec_instr, 32'h0000_ABCD);
        chk("strad_tail_pc", dec_pc, 32'h206);
        chk("strad_tail_npc", dec_npc, 32'h208);
        tick();
        dec_ready = 1'b0;
        chk("strad_end_count", {28'h0, count}, 32'd0);

        // Full. The first instruction lands in the last storage entry and
        // entry 0, so it wraps the pointers.
        do_flush(32'h0);
        push(32'h0, 32'h00A0_0093, 1'b0, 4'h0);
        push(32'h4, 32'h00B0_0113, 1'b0, 4'h0);
        push(32'h8, 32'h0001_0001, 1'b0, 4'h0);
        push(32'hC, 32'h0002_0002, 1'b0, 4'h0);
        chk("full_count", {28'h0, count}, 32'd8);
        chk("full_ready", {31'h0, fetch_ready}, 32'd0);
        chk("wrap_instr", dec_instr, 32'h00A0_0093);
        chk("wrap_npc", dec_npc, 32'h4);
        push(32'h10, 32'hFFFF_FFFF, 1'b0, 4'h0);
        chk("full_ignored_count", {28'h0, count}, 32'd8);
        dec_ready = 1'b1;
        tick();
        chk("full_pop_count", {28'h0, count}, 32'd6);
        chk("full_pop_instr", dec_instr, 32'h00B0_0113);
        chk("full_pop_pc", dec_pc, 32'h4);
        chk("full_ready_again", {31'h0, fetch_ready}, 32'd1);
        // Push and pop in the same cycle: +2 -2
        push(32'h10, 32'h00C0_0193, 1'b0, 4'h0);
        dec_ready = 1'b0;
        chk("pushpop_count", {28'h0, count}, 32'd6);
        chk("pushpop_instr", dec_instr, 32'h0000_0001);
        chk("pushpop_pc", dec_pc, 32'h8);
        chk("pushpop_npc", dec_npc, 32'hA);

        // Flush collides with a push: the word is dropped
        flush       = 1'b1;
        flush_pc    = 32'h400;
        push(32'h10, 32'h0000_0013, 1'b0, 4'h0);
        flush       = 1'b0;
        chk("coll_count", {28'h0, count}, 32'd0);
        chk("coll_valid", {31'h0, dec_valid}, 32'd0);
        chk("coll_pc", dec_pc, 32'h400);
        push(32'h14, 32'h0000_0013, 1'b0, 4'h0);
        chk("stale_count", {28'h0, count}, 32'd0);
        push(32'h400, 32'h0000_0013, 1'b0, 4'h0);
        chk("redir_count", {28'h0, count}, 32'd2);
        chk("redir_valid", {31'h0, dec_valid}, 32'd1);
        chk("redir_pc", dec_pc, 32'h400);

        // Second-parcel fault: 0x0513 at 0xFFE, faulting word at 0x1000
        do_flush(32'hFFE);
        push(32'hFFC, 32'h0513_0000, 1'b0, 4'h0);
        chk("f2_count1", {28'h0, count}, 32'd1);
        chk("f2_wait_valid", {31'h0, dec_valid}, 32'd0);
        push(32'h1000, 32'h0000_0010, 1'b1, 4'h1);
        chk("f2_valid", {31'h0, dec_valid}, 32'd1);
        chk("f2_exc", {31'h0, dec_exc}, 32'd1);
        chk("f2_ecause", {28'h0, dec_ecause}, 32'd1);
        chk("f2_etval", dec_etval, 32'h1000);
        chk("f2_npc", dec_npc, 32'h1002);
        dec_ready = 1'b1;
        tick();
        chk("f2_pop_count", {28'h0, count}, 32'd1);
        chk("f2_head_pc", dec_pc, 32'h1002);
        // Now the faulting parcel is at the head. It is issued alone.
        chk("f1_valid", {31'h0, dec_valid}, 32'd1);
        chk("f1_exc", {31'h0, dec_exc}, 32'd1);
        chk("f1_etval", dec_etval, 32'h1002);
        chk("f1_npc", dec_npc, 32'h1004);
        tick();
        dec_ready = 1'b0;
        chk("f1_end_count", {28'h0, count}, 32'd0);
        chk("f1_end_exc", {31'h0, dec_exc}, 32'd0);

        // npc wraps at 2^32
        do_flush(32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 4'h0);
        chk("wrap32_npc", dec_npc, 32'h0);
        chk("wrap32_count", {28'h0, count}, 32'd2);

        // Asynchronous reset mid-operation
        reset = 1'b0;
        #1;
        chk("arst_count", {28'h0, count}, 32'd0);
        chk("arst_valid", {31'h0, dec_valid}, 32'd0);
        chk("arst_ready", {31'h0, fetch_ready}, 32'd1);
        chk("arst_pc", dec_pc, 32'h0);
        #2;
        reset = 1'b1;
        tick();
        chk("arst_post_valid", {31'h0, dec_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
